uart_tx_fifo: RTL

// Parametrised UART transmitter with an integrated TX FIFO. It serialises

---
 rtl/uart_tx_fifo.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Purpose: UART transmitter with integrated TX FIFO, configurable data width, parity and stop bits.
// Latency: a word pushed into an empty FIFO with the FSM idle is popped one clock later; tx_line falls after that edge.
// Backpressure: tx_ready drops when the FIFO is full; a tx_start while full is dropped and pulses tx_overflow.
//
// Ports:
//   clk         - single clock, posedge
//   rstn        - asynchronous active-low reset
//   tx_data     - word to queue (DATA_BITS wide)
//   tx_start    - write strobe, accepted when tx_ready
//   tx_ready    - FIFO not full
//   tx_busy     - frame in progress
//   tx_line     - serial output, idle high
//   fifo_count  - words queued, excluding the word being sent
//   tx_done     - one-cycle pulse on the last cycle of the final stop bit
//   tx_overflow - one-cycle pulse when a tx_start is dropped
module uart_tx_fifo #(
  parameter int CLK_DIV    = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_start,
  output logic                          tx_ready,
  output logic                          tx_busy,
  output logic                          tx_line,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_done,
  output logic                          tx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and pointers
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          count;

  // Serialiser state
  state_t               state;
  logic [CW-1:0]        baud_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;

  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 baud_last;
  logic                 stop_last;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign head_par   = (PARITY == 1) ? ~^head : ^head;
  assign baud_last  = (baud_cnt == CW'(CLK_DIV - 1));
  assign stop_last  = (bit_idx == BW'(STOP_BITS - 1));

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when a pop happens on the same edge.
  assign tx_ready    = (count != (AW + 1)'(FIFO_DEPTH));
  assign tx_overflow = tx_start && !tx_ready;
  assign push        = tx_start && tx_ready;
  assign fifo_count  = count;

  // Pop from IDLE, or at the very end of the final stop bit for gap-free back-to-back frames.
  assign pop = !fifo_empty &&
               ((state == S_IDLE) || ((state == S_STOP) && stop_last && baud_last));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_line  <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == S_IDLE) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        tx_line  <= 1'b1;
        if (pop) begin
          shreg   <= head;
          par_bit <= head_par;
          state   <= S_START;
          tx_line <= 1'b0;
          tx_busy <= 1'b1;
        end
      end else if (!baud_last) begin
        baud_cnt <= baud_cnt + 1'b1;
        // Raise tx_done one edge early so the registered pulse lands on the final cycle.
        if ((state == S_STOP) && stop_last && (baud_cnt == CW'(CLK_DIV - 2))) begin
          tx_done <= 1'b1;
        end
      end else begin
        baud_cnt <= '0;
        case (state)
          S_START: begin
            state   <= S_DATA;
            bit_idx <= '0;
            tx_line <= shreg[0];
          end
          S_DATA: begin
            if (bit_idx == BW'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                state   <= S_PARITY;
                tx_line <= par_bit;
              end else begin
                state   <= S_STOP;
                tx_line <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shreg   <= shreg >> 1;
              tx_line <= shreg[1];
            end
          end
          S_PARITY: begin
            state   <= S_STOP;
            bit_idx <= '0;
            tx_line <= 1'b1;
          end
          S_STOP: begin
            if (stop_last) begin
              bit_idx <= '0;
              if (pop) begin
                shreg   <= head;
                par_bit <= head_par;
                state   <= S_START;
                tx_line <= 1'b0;
              end else begin
                state   <= S_IDLE;
                tx_line <= 1'b1;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          default: begin
            state   <= S_IDLE;
            tx_line <= 1'b1;
            tx_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
